// File: rtl/lcd_write_arbiter_if.sv
// Bundle of requester, LCD driver and status signals shared by the arbiter and its neighbours.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface lcd_write_arbiter_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_lock;
  logic       req0_ready;

  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_lock;
  logic       req1_ready;

  logic       lcd_valid;
  logic       lcd_rs;
  logic [7:0] lcd_data;
  logic       lcd_ready;
  logic       lcd_done;

  logic [1:0] grant;
  logic       timeout_err;
  logic       err_clr;

  modport slave (
    input  req0_valid, req0_rs, req0_data, req0_lock,
    output req0_ready,
    input  req1_valid, req1_rs, req1_data, req1_lock,
    output req1_ready,
    output lcd_valid, lcd_rs, lcd_data,
    input  lcd_ready, lcd_done,
    output grant, timeout_err,
    input  err_clr
  );

  modport master (
    output req0_valid, req0_rs, req0_data, req0_lock,
    input  req0_ready,
    output req1_valid, req1_rs, req1_data, req1_lock,
    input  req1_ready,
    input  lcd_valid, lcd_rs, lcd_data,
    output lcd_ready, lcd_done,
    input  grant, timeout_err,
    output err_clr
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one LCD write path between two requesters, with an ownership
// lock for multi-word sequences and a watchdog that aborts any stalled transaction.
module lcd_write_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned TIMER_W        = 10
) (
  input logic                  clk,
  input logic                  rst,
  lcd_write_arbiter_if.slave   bus
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StIssue    = 2'd1;
  localparam logic [1:0] StWaitDone = 2'd2;
  localparam logic [1:0] StHold     = 2'd3;

  // Timer holds k in the k+1'th cycle of a state, so exit fires when it shows TIMEOUT_CYCLES-1.
  localparam logic [TIMER_W-1:0] TimeoutLast = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic               prio_q, prio_d;
  logic [1:0]         grant_q, grant_d;
  logic               lock_q, lock_d;
  logic               rs_q, rs_d;
  logic [7:0]         data_q, data_d;
  logic               err_q, err_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic sel0, sel1;
  logic xfer0, xfer1, xfer;
  logic timeout;
  logic err_set;

  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    unique case (state_q)
      StIdle: begin
        sel0 = bus.req0_valid & (~bus.req1_valid | ~prio_q);
        sel1 = bus.req1_valid & (~bus.req0_valid |  prio_q);
      end
      StHold: begin
        sel0 = grant_q[0];
        sel1 = grant_q[1];
      end
      default: ;
    endcase
  end

  assign xfer0   = sel0 & bus.req0_valid;
  assign xfer1   = sel1 & bus.req1_valid;
  assign xfer    = xfer0 | xfer1;
  assign timeout = (timer_q == TimeoutLast);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    lock_d  = lock_q;
    rs_d    = rs_q;
    data_d  = data_q;
    timer_d = timer_q + 1'b1;
    err_set = 1'b0;

    if (xfer) begin
      rs_d    = xfer1 ? bus.req1_rs   : bus.req0_rs;
      data_d  = xfer1 ? bus.req1_data : bus.req0_data;
      lock_d  = xfer1 ? bus.req1_lock : bus.req0_lock;
      grant_d = {xfer1, xfer0};
    end

    unique case (state_q)
      StIdle: begin
        if (xfer) state_d = StIssue;
      end
      StIssue: begin
        if (bus.lcd_ready) begin
          state_d = StWaitDone;
        end else if (timeout) begin
          state_d = StIdle;
          grant_d = 2'b00;
          prio_d  = ~prio_q;
          err_set = 1'b1;
        end
      end
      StWaitDone: begin
        if (bus.lcd_done) begin
          if (lock_q) begin
            state_d = StHold;
          end else begin
            state_d = StIdle;
            grant_d = 2'b00;
            prio_d  = grant_q[0];
          end
        end else if (timeout) begin
          state_d = StIdle;
          grant_d = 2'b00;
          prio_d  = ~prio_q;
          err_set = 1'b1;
        end
      end
      StHold: begin
        if (xfer) begin
          state_d = StIssue;
        end else if (timeout) begin
          state_d = StIdle;
          grant_d = 2'b00;
        end
      end
      default: state_d = StIdle;
    endcase

    // Every transition changes state, so a state change is exactly a state entry.
    if (state_d != state_q || state_q == StIdle) timer_d = '0;

    err_d = err_q;
    if (bus.err_clr) err_d = 1'b0;
    if (err_set)     err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      grant_q <= 2'b00;
      lock_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign bus.req0_ready  = sel0;
  assign bus.req1_ready  = sel1;
  assign bus.lcd_valid   = (state_q == StIssue);
  assign bus.lcd_rs      = rs_q;
  assign bus.lcd_data    = data_q;
  assign bus.grant       = grant_q;
  assign bus.timeout_err = err_q;

endmodule
